// File: rtl/conv_window_read_sequencer_if.sv
// Bundles the pass-control inputs and the per-window read controls that go
// to the feature-map memory and the gating stage.
interface conv_window_read_sequencer_if #(
    parameter int width_b  = 7,
    parameter int height_b = 3
);
    logic                start;
    logic                pad_en;
    logic [width_b:0]    img_w;
    logic [height_b:0]   img_h;
    logic                stall;
    logic [width_b-1:0]  col_addr;
    logic [height_b-1:0] row_addr;
    logic [8:0]          en_read;
    logic                en_bias;
    logic                busy;
    logic                done;

    modport master (
        output start, pad_en, img_w, img_h, stall,
        input  col_addr, row_addr, en_read, en_bias, busy, done
    );

    modport slave (
        input  start, pad_en, img_w, img_h, stall,
        output col_addr, row_addr, en_read, en_bias, busy, done
    );
endinterface

// File: rtl/conv_window_read_sequencer.sv
// Walks a 3x3 window over the feature map in raster order, issuing a bias
// strobe first and then one centre address plus tap-valid mask per window.
module conv_window_read_sequencer #(
    parameter int width_b  = 7,
    parameter int height_b = 3
) (
    input logic clk,
    input logic reset,
    conv_window_read_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BIAS = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [width_b:0]  W_MIN = (width_b+1)'(3);
    localparam logic [height_b:0] H_MIN = (height_b+1)'(3);
    localparam logic [width_b:0]  W_MAX = {1'b1, {width_b{1'b0}}};
    localparam logic [height_b:0] H_MAX = {1'b1, {height_b{1'b0}}};

    logic [1:0]          state;
    logic [width_b:0]    w_q;
    logic [height_b:0]   h_q;
    logic                pad_q;
    logic [width_b-1:0]  col;
    logic [height_b-1:0] row;

    logic [width_b:0]    col_x, col_m1, col_p1, last_col;
    logic [height_b:0]   row_x, row_m1, row_p1, last_row;
    logic [2:0]          row_ok, col_ok;
    logic [8:0]          mask;
    logic                at_last_col, at_last_row, dims_ok;
    logic [width_b-1:0]  first_col, start_col;
    logic [height_b-1:0] first_row, start_row;

    // Neighbour coordinates are one bit wider so that -1 underflows to a value
    // above any legal dimension and +1 at the edge does not wrap to zero.
    always_comb begin
        col_x    = {1'b0, col};
        row_x    = {1'b0, row};
        col_m1   = col_x - 1'b1;
        col_p1   = col_x + 1'b1;
        row_m1   = row_x - 1'b1;
        row_p1   = row_x + 1'b1;
        row_ok   = {row_m1 < h_q, 1'b1, row_p1 < h_q};
        col_ok   = {col_m1 < w_q, 1'b1, col_p1 < w_q};
        mask     = {{3{row_ok[2]}}, {3{row_ok[1]}}, {3{row_ok[0]}}} & {3{col_ok}};
        last_col = pad_q ? (w_q - 1'b1) : (w_q - 2'd2);
        last_row = pad_q ? (h_q - 1'b1) : (h_q - 2'd2);
        at_last_col = (col_x == last_col);
        at_last_row = (row_x == last_row);
        first_col = {{(width_b-1){1'b0}}, ~pad_q};
        first_row = {{(height_b-1){1'b0}}, ~pad_q};
        start_col = {{(width_b-1){1'b0}}, ~bus.pad_en};
        start_row = {{(height_b-1){1'b0}}, ~bus.pad_en};
        dims_ok  = (bus.img_w >= W_MIN) && (bus.img_w <= W_MAX) &&
                   (bus.img_h >= H_MIN) && (bus.img_h <= H_MAX);
    end

    // Outputs are registered from the state being left, so each state's
    // strobes appear in the cycle after the edge that acts on it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            w_q          <= '0;
            h_q          <= '0;
            pad_q        <= 1'b0;
            col          <= '0;
            row          <= '0;
            bus.col_addr <= '0;
            bus.row_addr <= '0;
            bus.en_read  <= '0;
            bus.en_bias  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.col_addr <= '0;
                    bus.row_addr <= '0;
                    bus.en_read  <= '0;
                    bus.en_bias  <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b0;
                    if (bus.start && dims_ok) begin
                        w_q   <= bus.img_w;
                        h_q   <= bus.img_h;
                        pad_q <= bus.pad_en;
                        col   <= start_col;
                        row   <= start_row;
                        state <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    bus.col_addr <= col;
                    bus.row_addr <= row;
                    bus.en_read  <= '0;
                    bus.en_bias  <= 1'b1;
                    bus.busy     <= 1'b1;
                    bus.done     <= 1'b0;
                    state        <= S_RUN;
                end
                S_RUN: begin
                    bus.col_addr <= col;
                    bus.row_addr <= row;
                    bus.en_bias  <= 1'b0;
                    bus.busy     <= 1'b1;
                    bus.done     <= 1'b0;
                    if (bus.stall) begin
                        bus.en_read <= '0;
                    end else begin
                        bus.en_read <= mask;
                        if (at_last_col) begin
                            col <= first_col;
                            if (at_last_row)
                                state <= S_DONE;
                            else
                                row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    bus.col_addr <= '0;
                    bus.row_addr <= '0;
                    bus.en_read  <= '0;
                    bus.en_bias  <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/conv_window_read_sequencer.md
Name: conv_window_read_sequencer

Overview:
Generates the per-cycle read controls for the 9-bank feature-map memory and the PE-side zero-pad gating stage. It walks a 3x3 convolution window across an img_h x img_w feature map in raster order. Per window it emits the centre address plus the 9-bit en_read tap-valid mask, and it emits the en_bias pulse that precedes each map pass. Its outputs feed the memory address inputs and the en_read/en_bias inputs of the gating stage, which delays them one cycle to align with memory read data.

Parameters:
width_b, 7, column address width; maximum img_w = 2^width_b
height_b, 3, row address width; maximum img_h = 2^height_b

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  begin a pass; sampled only in IDLE
pad_en  input  1  1 = same-size output with zero padding, 0 = valid-only windows; latched at start
img_w  input  width_b+1  map width; legal range 3..2^width_b; latched at start
img_h  input  height_b+1  map height; legal range 3..2^height_b; latched at start
stall  input  1  downstream hold request; freezes window advance
col_addr  output  width_b  window centre column
row_addr  output  height_b  window centre row
en_read  output  9  tap-valid mask. Bit 8 = (r-1,c-1), 7 = (r-1,c), 6 = (r-1,c+1), 5 = (r,c-1), 4 = (r,c), 3 = (r,c+1), 2 = (r+1,c-1), 1 = (r+1,c), 0 = (r+1,c+1)
en_bias  output  1  bias load strobe
busy  output  1  high in BIAS and RUN
done  output  1  one-cycle pulse after the last window

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Registered outputs: all outputs come from registers. Reset values are all zero; reset forces state IDLE.
- Reset mid-pass: aborts the pass. Outputs are zero on the next edge and done is not pulsed.
- State IDLE:
  - start=1 with legal dims: latch img_w, img_h and pad_en.
  - Set row/col to the first centre: (0,0) if pad_en=1, (1,1) if pad_en=0.
  - Go to BIAS.
  - start with img_w<3 or img_h<3: ignored, remain IDLE.
- State BIAS: exactly one cycle, with en_bias=1, en_read=0 and busy=1. Unconditionally go to RUN; stall is ignored here.
- State RUN, stall=0:
  - en_read = computed mask; row_addr/col_addr = current centre; en_bias=0.
  - Advance col. At the last column, wrap col to the first column and increment row.
- State RUN, stall=1: en_read=0 and position holds. The window is re-issued on the first non-stalled cycle.
- Last-column / last-row bounds: last column is img_w-1 (pad) or img_w-2 (valid). Last row is img_h-1 (pad) or img_h-2 (valid).
- Mask rule: a tap's bit is 1 iff its row lies in 0..img_h-1 and its column lies in 0..img_w-1. With pad_en=0 every emitted mask is 9'h1FF.
- Window count: img_h*img_w (pad) or (img_h-2)*(img_w-2) (valid).
- Pass timing: start is sampled at edge N. en_bias is high in cycle N+1. Windows are issued from N+2 onward, one per non-stalled cycle.
- End of pass: after the last window issues, go to DONE. DONE lasts one cycle with done=1 and busy=0, then returns to IDLE.
- start asserted in any state other than IDLE is ignored.
- Address arithmetic: centre ±1 is computed at width_b+1 / height_b+1 bits so that edge taps at -1 and at img_w / img_h are detected without wrap. Address outputs never leave the legal centre range.

Test Plan:
- reset held 2 cycles, then start with img_w=3, img_h=3, pad_en=1, stall=0.
  - Response: en_bias=1 for one cycle, then 9 windows.
  - Masks: (0,0)=9'h01B, (0,1)=9'h03F, (1,1)=9'h1FF, (2,2)=9'h1B0.
  - done pulses exactly 11 cycles after the start edge.
- start with img_w=5, img_h=4, pad_en=0.
  - Response: 6 windows with centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3), all with en_read=9'h1FF.
  - busy high for 7 cycles.
- Padded 4x4 with stall=1 for 3 cycles while the window at (1,2) is due.
  - During the stall: en_read=0 and addresses hold.
  - (1,2) issues once after the stall releases; total windows = 16.
- Dimension boundaries.
  - img_w=128, img_h=8, pad_en=1: col wraps from 127 to 0 without overflow, the row increments, and the final window is (7,127) with mask 9'h1B0.
  - start with img_w=2: no state change and no done.
- Reset and start-while-busy.
  - reset asserted during RUN at window 5: next cycle all outputs are 0 and the block is in IDLE.
  - A new start then restarts from (0,0).
  - start pulsed during RUN has no effect.
